fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
- Multi-cycle FP32 (IEEE-754 single) multiplier sequencer with valid/ready handshakes on input and output.
- Time-shares one 10-bit exponent add/subtract unit across three uses: exponent sum, bias removal, and normalisation increment.
- Drives a radix-2 shift-add mantissa multiply over 24 cycles.
- Sits between the operand issue stage and the result writeback of the FP unit's multiply path.

Parameters:
- MANT_W, 24, significand width including hidden bit
- EXP_W, 8, exponent field width
- BIAS, 127, exponent bias

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block idle and able to accept
- a  in  32  FP32 operand A
- b  in  32  FP32 operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  FP32 product
- flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, result=0, flags=0, state=IDLE, cycle counter=0.
- FSM states: IDLE, EXP_ADD, EXP_BIAS, MULT, NORM, ROUND, DONE.
- IDLE: in_ready=1.
  - in_valid&in_ready at edge k latches a and b, then goes to EXP_ADD.
  - in_ready is 0 in every other state; no new operand is accepted until DONE completes.
- EXP_ADD: shared unit computes ea+eb (10-bit, zero-extended). Special-case detection happens here:
  - NaN operand, or inf×0: result=0x7FC00000, invalid=1.
  - inf×finite: result=±inf (0x7F800000 | sign).
  - zero or denormal operand: denormals are flushed; result=±0.
  - Any special case jumps directly to DONE, so out_valid rises after edge k+2.
- EXP_BIAS: shared unit computes sum − BIAS, giving a signed 10-bit exponent.
- MULT: 24 cycles, counter 0..23.
  - Each cycle: if multiplier LSB is 1, add multiplicand into the upper half of the 48-bit accumulator; then shift right by 1.
  - Leave MULT when counter=23.
- NORM: if prod[47]=1, shift right 1 and increment the exponent through the shared unit. Otherwise no change.
- ROUND: truncate to 23 fraction bits. inexact = OR of discarded bits.
  - exp ≥ 255: ±inf, overflow=1, inexact=1.
  - exp ≤ 0: ±0, underflow=1, inexact=1.
- Sign: sa^sb for every result, including ±0 and ±inf. NaN sign is always 0.
- Normal-path latency: out_valid first high after edge k+28 (EXP_ADD 1 + EXP_BIAS 1 + MULT 24 + NORM 1 + ROUND 1).
- DONE: out_valid=1. result and flags hold stable while out_ready=0.
  - out_valid&out_ready goes to IDLE: out_valid=0 and in_ready=1 next cycle.
  - There is no same-cycle turnaround; in_valid is ignored while in DONE.
- Reset mid-operation: an asynchronous return to the reset values; the in-flight operation is discarded with no output.
- The shared exponent unit has exactly one user per state; its operands are muxed by state.

Optional Feature:
- FP_MUL_RNE_EN defined: ROUND applies round-to-nearest-even using guard/round/sticky bits.
  - A mantissa carry-out increments the exponent, then the overflow check is repeated.
  - ROUND takes 1 cycle, so latency is unchanged.
- FP_MUL_RNE_EN undefined: truncation (round toward zero).
- flags.inexact has the same definition in both builds.

Decomposition:
- Package fp_mul_pkg:
  - state enum
  - FP32 field widths and BIAS
  - QNAN=0x7FC00000 and PINF=0x7F800000
  - flag bit indices
  - typedef of an unpacked FP32 struct {sign, exp, frac}
- One sub-module, fp_exp_addsub: a 10-bit adder/subtractor (op select, a, b → sum), instanced once and muxed by the FSM.

Test Plan:
- 2.0×3.0 (0x40000000, 0x40400000) → result 0x40C00000, flags 0, out_valid exactly 28 cycles after accept.
- 1.5×1.5 (0x3FC00000 ×2) → 0x40100000 (NORM shift path), flags 0.
- 0x3FC00001×0x3FC00001 → with FP_MUL_RNE_EN 0x40100002, without it 0x40100001; inexact=1 in both.
- inf×0 (0x7F800000, 0x00000000) → 0x7FC00000, invalid=1, latency 2. −2.0×0 → 0x80000000.
- 0x7F000000×0x7F000000 → 0x7F800000 with overflow=1. 0x00800000×0x00800000 → 0x00000000 with underflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE: result stable, in_ready=0.
  - Deassert rst_n during MULT cycle 12: all outputs return to reset values immediately; the next transaction 2.0×3.0 completes correctly.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential FP32 multiplier.
package fp_mul_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = FP_FRAC_W + 1;
  localparam int FP_BIAS   = 127;
  // Internal exponent width: two 8-bit exponents plus a sign bit for the
  // biased-removed value.
  localparam int XW        = 10;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXP_ADD  = 3'd1,
    EXP_BIAS = 3'd2,
    MULT     = 3'd3,
    NORM     = 3'd4,
    ROUND    = 3'd5,
    DONE     = 3'd6
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_exp_addsub.sv
// Shared 10-bit exponent adder/subtractor; one instance, operands muxed by the FSM.
module fp_exp_addsub #(
  parameter int W = 10
) (
  input  logic         op_sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  // Single add/subtract selected by op_sub.
  always_comb begin
    sum = op_sub ? (x - y) : (x + y);
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle FP32 multiplier: shared exponent unit, 24-cycle shift-add
// mantissa multiply, flush-to-zero of denormals.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and
// result/flags stay stable for as long as out_valid is high.
// Optional build macro FP_MUL_RNE_EN: round-to-nearest-even instead of
// truncation in ROUND (latency unchanged).
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  dbg_state
);

  state_t state, state_nx;

  logic [31:0]           a_q, b_q;
  fp32_t                 fa, fb;
  logic                  special_q;
  logic signed [XW-1:0]  exp_r;
  logic [2*MANT_W-1:0]   prod;
  logic                  sticky_q;
  logic [4:0]            cnt;

  logic                  au_sub;
  logic [XW-1:0]         au_x, au_y, au_sum;

  logic                  sign;
  logic [MANT_W-1:0]     ma;
  logic [MANT_W:0]       upper_sum;

  logic                  is_special;
  logic [31:0]           spec_res;
  logic [3:0]            spec_flags;

  logic [MANT_W-1:0]     mant;
  logic                  guard, rsticky, rnd_up;
  logic [MANT_W:0]       mant_rnd;
  logic signed [XW-1:0]  exp_fin;
  logic [FP_FRAC_W-1:0]  frac_fin;
  logic [31:0]           rnd_res;
  logic [3:0]            rnd_flags;

  assign fa        = a_q;
  assign fb        = b_q;
  assign sign      = fa.sign ^ fb.sign;
  assign ma        = {1'b1, fa.frac};
  assign dbg_state = state;

  fp_exp_addsub #(.W(XW)) u_exp (
    .op_sub (au_sub),
    .x      (au_x),
    .y      (au_y),
    .sum    (au_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = EXP_ADD;
      end
      EXP_ADD:  state_nx = EXP_BIAS;
      // Special results were settled in EXP_ADD; they leave one slot later.
      EXP_BIAS: state_nx = special_q ? DONE : MULT;
      MULT:     if (cnt == 5'(MANT_W - 1)) state_nx = NORM;
      NORM:     state_nx = ROUND;
      ROUND:    state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Shared exponent unit operand mux: one user per state.
  always_comb begin
    au_sub = 1'b0;
    au_x   = '0;
    au_y   = '0;
    case (state)
      EXP_ADD: begin
        au_x = {2'b00, fa.exp};
        au_y = {2'b00, fb.exp};
      end
      EXP_BIAS: begin
        au_sub = 1'b1;
        au_x   = exp_r;
        au_y   = XW'(BIAS);
      end
      NORM, ROUND: begin
        au_x = exp_r;
        au_y = XW'(1);
      end
      default: ;
    endcase
  end

  // Special-operand classification (denormals count as zero).
  always_comb begin
    logic a_max, b_max, a_zero, b_zero, a_nan, b_nan;
    a_max      = (fa.exp == '1);
    b_max      = (fb.exp == '1);
    a_zero     = (fa.exp == '0);
    b_zero     = (fb.exp == '0);
    a_nan      = a_max && (fa.frac != '0);
    b_nan      = b_max && (fb.frac != '0);
    is_special = a_max || b_max || a_zero || b_zero;
    spec_flags = '0;
    if (a_nan || b_nan || (a_max && b_zero) || (b_max && a_zero)) begin
      spec_res                = QNAN;
      spec_flags[FLG_INVALID] = 1'b1;
    end else if (a_max || b_max) begin
      spec_res = PINF | {sign, 31'b0};
    end else begin
      spec_res = {sign, 31'b0};
    end
  end

  // One shift-add step: add multiplicand into the upper half when LSB set.
  always_comb begin
    upper_sum = {1'b0, prod[2*MANT_W-1:MANT_W]} + (prod[0] ? {1'b0, ma} : '0);
  end

  // Rounding, exponent range checks and final packing.
  always_comb begin
    mant    = prod[2*MANT_W-2:MANT_W-1];
    guard   = prod[MANT_W-2];
    rsticky = (|prod[MANT_W-3:0]) | sticky_q;
`ifdef FP_MUL_RNE_EN
    rnd_up  = guard & (rsticky | prod[MANT_W-1]);
`else
    rnd_up  = 1'b0;
`endif
    mant_rnd = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
    exp_fin  = mant_rnd[MANT_W] ? $signed(au_sum) : exp_r;
    frac_fin = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[MANT_W-2:0];
    rnd_flags = '0;
    rnd_flags[FLG_INEXACT] = guard | rsticky;
    if (exp_fin >= 10'sd255) begin
      rnd_res                   = PINF | {sign, 31'b0};
      rnd_flags[FLG_OVERFLOW]   = 1'b1;
      rnd_flags[FLG_INEXACT]    = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      rnd_res                   = {sign, 31'b0};
      rnd_flags[FLG_UNDERFLOW]  = 1'b1;
      rnd_flags[FLG_INEXACT]    = 1'b1;
    end else begin
      rnd_res = {sign, exp_fin[EXP_W-1:0], frac_fin};
    end
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      special_q <= 1'b0;
      exp_r     <= '0;
      prod      <= '0;
      sticky_q  <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            special_q <= 1'b0;
            sticky_q  <= 1'b0;
            cnt       <= '0;
          end
        end
        EXP_ADD: begin
          exp_r <= $signed(au_sum);
          prod  <= {{MANT_W{1'b0}}, 1'b1, fb.frac};
          if (is_special) begin
            special_q <= 1'b1;
            result    <= spec_res;
            flags     <= spec_flags;
          end
        end
        EXP_BIAS: exp_r <= $signed(au_sum);
        MULT: begin
          prod <= {upper_sum, prod[MANT_W-1:1]};
          cnt  <= (cnt == 5'(MANT_W - 1)) ? '0 : cnt + 5'd1;
        end
        NORM: begin
          if (prod[2*MANT_W-1]) begin
            prod     <= {1'b0, prod[2*MANT_W-1:1]};
            sticky_q <= prod[0];
            exp_r    <= $signed(au_sum);
          end
        end
        ROUND: begin
          result <= rnd_res;
          flags  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
